mu0_run_ctrl: RTL and testbench



---
 rtl/mu0_run_ctrl_if.sv | 24 ++
 rtl/mu0_run_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mu0_run_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mu0_run_ctrl_if.sv
// Host/debug command port of the MU0 run-control block.
// The host drives commands; the controller answers with ready, done, err and read data.
interface mu0_run_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [15:0]       cmd_arg;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_done;
    logic              cmd_err;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_wdata,
        input  cmd_ready, cmd_done, cmd_err, host_rdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_wdata,
        output cmd_ready, cmd_done, cmd_err, host_rdata
    );
endinterface

// File: rtl/mu0_run_ctrl.sv
// MU0 run control: clock-enable gating for run/halt/step/breakpoint, STP detection,
// and arbitration of the single shared memory between the core and the host port.
module mu0_run_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    mu0_run_ctrl_if.slave     host,
    output logic              cpu_en,
    input  logic              cpu_fetch,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        run_state,
    output logic [1:0]        halt_reason
);

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpRun   = 3'd1;
    localparam logic [2:0] OpHalt  = 3'd2;
    localparam logic [2:0] OpStep  = 3'd3;
    localparam logic [2:0] OpSetbp = 3'd4;
    localparam logic [2:0] OpMemrd = 3'd5;
    localparam logic [2:0] OpMemwr = 3'd6;

    typedef enum logic [2:0] {StHalted, StRun, StStep, StStopped, StMemAcc} state_e;

    state_e            state_q, ret_q;
    logic              stop_req_q, skip_bp_q, exec_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bp_en_q;
    logic [ADDR_W-1:0] bp_addr_q;
    logic [ADDR_W-1:0] macc_addr_q;
    logic [DATA_W-1:0] macc_wdata_q, host_rdata_q;
    logic              macc_wr_q, done_q, err_q;
    logic [1:0]        halt_reason_q;

    logic accept, running, hit_step, hit_bp, halt_now;

    assign host.cmd_ready  = (state_q != StMemAcc);
    assign host.cmd_done   = done_q;
    assign host.cmd_err    = err_q;
    assign host.host_rdata = host_rdata_q;
    assign halt_reason     = halt_reason_q;

    assign accept   = host.cmd_valid && host.cmd_ready;
    assign running  = (state_q == StRun) || (state_q == StStep);
    assign hit_step = (state_q == StStep) && (cnt_q == '0);
    assign hit_bp   = bp_en_q && (cpu_pc == bp_addr_q) && !skip_bp_q;
    // Halts only at a fetch boundary so the instruction at cpu_pc is never started.
    assign halt_now = running && cpu_fetch && (stop_req_q || hit_step || hit_bp);
    assign cpu_en   = running && !halt_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHalted;
            ret_q         <= StHalted;
            stop_req_q    <= 1'b0;
            skip_bp_q     <= 1'b0;
            exec_q        <= 1'b0;
            cnt_q         <= '0;
            bp_en_q       <= 1'b0;
            bp_addr_q     <= '0;
            macc_addr_q   <= '0;
            macc_wdata_q  <= '0;
            macc_wr_q     <= 1'b0;
            host_rdata_q  <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            halt_reason_q <= 2'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept && host.cmd_op == OpSetbp) begin
                bp_en_q   <= host.cmd_arg[12];
                bp_addr_q <= host.cmd_arg[ADDR_W-1:0];
            end
            unique case (state_q)
                StHalted: begin
                    if (accept) begin
                        case (host.cmd_op)
                            OpRun: begin
                                state_q   <= StRun;
                                skip_bp_q <= 1'b1;
                                exec_q    <= 1'b0;
                            end
                            OpStep: begin
                                state_q   <= StStep;
                                skip_bp_q <= 1'b1;
                                exec_q    <= 1'b0;
                                cnt_q     <= (host.cmd_arg == 16'd0) ? CNT_W'(1)
                                                                     : CNT_W'(host.cmd_arg);
                            end
                            OpMemrd, OpMemwr: begin
                                state_q      <= StMemAcc;
                                ret_q        <= StHalted;
                                macc_addr_q  <= host.cmd_arg[ADDR_W-1:0];
                                macc_wdata_q <= host.cmd_wdata;
                                macc_wr_q    <= (host.cmd_op == OpMemwr);
                            end
                            OpNop, OpHalt, OpSetbp: ;
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StRun, StStep: begin
                    if (accept) begin
                        case (host.cmd_op)
                            OpHalt: stop_req_q <= 1'b1;
                            OpNop, OpRun, OpSetbp: ;
                            default: err_q <= 1'b1;
                        endcase
                    end
                    // Later assignments override the command decode above on exit.
                    if (halt_now) begin
                        state_q    <= StHalted;
                        stop_req_q <= 1'b0;
                        exec_q     <= 1'b0;
                        if (stop_req_q)    halt_reason_q <= 2'd1;
                        else if (hit_step) halt_reason_q <= 2'd2;
                        else               halt_reason_q <= 2'd3;
                    end else if (cpu_fetch) begin
                        skip_bp_q <= 1'b0;
                        exec_q    <= 1'b0;
                    end else begin
                        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                        exec_q <= 1'b1;
                        if (exec_q) begin
                            state_q    <= StStopped;
                            stop_req_q <= 1'b0;
                            exec_q     <= 1'b0;
                        end
                    end
                end
                StStopped: begin
                    if (accept) begin
                        case (host.cmd_op)
                            OpMemrd, OpMemwr: begin
                                state_q      <= StMemAcc;
                                ret_q        <= StStopped;
                                macc_addr_q  <= host.cmd_arg[ADDR_W-1:0];
                                macc_wdata_q <= host.cmd_wdata;
                                macc_wr_q    <= (host.cmd_op == OpMemwr);
                            end
                            OpNop, OpHalt, OpSetbp: ;
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StMemAcc: begin
                    state_q <= ret_q;
                    done_q  <= 1'b1;
                    if (!macc_wr_q) host_rdata_q <= mem_rdata;
                end
                default: state_q <= StHalted;
            endcase
        end
    end

    always_comb begin
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        if (cpu_en) begin
            mem_address = cpu_address;
            mem_read    = cpu_read;
            mem_write   = cpu_write;
            mem_wdata   = cpu_wdata;
        end else if (state_q == StMemAcc) begin
            mem_address = macc_addr_q;
            mem_read    = !macc_wr_q;
            mem_write   = macc_wr_q;
            mem_wdata   = macc_wdata_q;
        end
    end

    always_comb begin
        run_state = 2'd0;
        unique case (state_q)
            StRun, StStep: run_state = 2'd1;
            StStopped:     run_state = 2'd2;
            StMemAcc:      run_state = 2'd3;
            default:       run_state = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_mu0_run_ctrl.sv
// Directed bench for mu0_run_ctrl: a command table from HALTED, then hand-written
// run/halt/step/breakpoint/STP/reset sequences against a small MU0 core and memory model.
module tb_mu0_run_ctrl;

    localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3;
    localparam logic [2:0] SETBP = 3'd4, MEMRD = 3'd5, MEMWR = 3'd6, BADOP = 3'd7;

    logic        clk, rst;
    logic        cpu_en;
    logic        cpu_fetch;
    logic [11:0] cpu_pc;
    logic        cpu_write;
    logic [15:0] cpu_wdata;
    logic [11:0] mem_address;
    logic        mem_read, mem_write;
    logic [15:0] mem_wdata, mem_rdata;
    logic [1:0]  run_state, halt_reason;

    logic        core_load, stp_on;
    logic [11:0] load_pc, stp_pc;
    logic [15:0] mem [4096];

    int n_vec = 0;
    int n_bad = 0;
    int n_ex;

    mu0_run_ctrl_if #(.DATA_W(16)) hif ();

    mu0_run_ctrl #(.ADDR_W(12), .DATA_W(16), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .cpu_en      (cpu_en),
        .cpu_fetch   (cpu_fetch),
        .cpu_pc      (cpu_pc),
        .cpu_address (cpu_pc),
        .cpu_read    (cpu_fetch),
        .cpu_write   (cpu_write),
        .cpu_wdata   (cpu_wdata),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .run_state   (run_state),
        .halt_reason (halt_reason)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight-line core: fetch/execute alternate; an STP at stp_pc stays in execute.
    always @(posedge clk) begin
        if (core_load) begin
            cpu_pc    <= load_pc;
            cpu_fetch <= 1'b1;
        end else if (cpu_en) begin
            if (cpu_fetch) begin
                cpu_fetch <= 1'b0;
            end else if (!(stp_on && cpu_pc == stp_pc)) begin
                cpu_pc    <= cpu_pc + 12'd1;
                cpu_fetch <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_address];
    assign cpu_write = 1'b0;
    assign cpu_wdata = 16'h0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] arg;
        logic [15:0] wdata;
        logic [1:0]  st;
        logic        rdy;
        logic        err;
        logic        done;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [2:0] op, input logic [15:0] arg, input logic [15:0] wd);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_arg   = arg;
        hif.cmd_wdata = wd;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = NOP;
    endtask

    task automatic load_core(input logic [11:0] pc);
        core_load = 1'b1;
        load_pc   = pc;
        @(negedge clk);
        core_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{NOP,   16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{HALT,  16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{SETBP, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{MEMWR, 16'h0010, 16'hBEEF, 2'd3, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{MEMRD, 16'h0010, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        vecs[5] = '{MEMWR, 16'h0020, 16'h1234, 2'd3, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        vecs[6] = '{MEMRD, 16'h0020, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[7] = '{BADOP, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 16'h1234};
        vecs[8] = '{MEMRD, 16'h0010, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b1, 16'hBEEF};

        rst = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = NOP;
        hif.cmd_arg   = 16'h0;
        hif.cmd_wdata = 16'h0;
        core_load = 1'b1;
        load_pc   = 12'h000;
        stp_on    = 1'b0;
        stp_pc    = 12'h000;
        @(negedge clk);
        @(negedge clk);
        check("rst cpu_en", cpu_en, 0);
        check("rst run_state", run_state, 0);
        check("rst halt_reason", halt_reason, 0);
        check("rst cmd_ready", hif.cmd_ready, 1);
        check("rst host_rdata", hif.host_rdata, 0);
        check("rst mem_write", mem_write, 0);
        rst = 1'b0;
        core_load = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].op, vecs[i].arg, vecs[i].wdata);
            check($sformatf("v%0d run_state", i), run_state, vecs[i].st);
            check($sformatf("v%0d cmd_ready", i), hif.cmd_ready, vecs[i].rdy);
            check($sformatf("v%0d cmd_err", i), hif.cmd_err, vecs[i].err);
            check($sformatf("v%0d mem_write", i), mem_write, vecs[i].op == MEMWR);
            check($sformatf("v%0d mem_read", i), mem_read, vecs[i].op == MEMRD);
            if (vecs[i].st == 2'd3)
                check($sformatf("v%0d mem_address", i), mem_address, vecs[i].arg[11:0]);
            if (vecs[i].op == MEMWR)
                check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
            @(negedge clk);
            check($sformatf("v%0d cmd_done", i), hif.cmd_done, vecs[i].done);
            check($sformatf("v%0d host_rdata", i), hif.host_rdata, vecs[i].rdata);
            check($sformatf("v%0d back halted", i), run_state, 0);
            check($sformatf("v%0d ready again", i), hif.cmd_ready, 1);
        end

        // Run, then HALT seven cycles in: stops at the next fetch (pc 4).
        load_core(12'h000);
        send(RUN, 16'h0, 16'h0);
        check("run run_state", run_state, 1);
        repeat (6) @(negedge clk);
        send(HALT, 16'h0, 16'h0);
        check("halt exec still enabled", cpu_en, 1);
        @(negedge clk);
        check("halt cpu_en", cpu_en, 0);
        check("halt pc", cpu_pc, 12'h004);
        check("halt fetch", cpu_fetch, 1);
        @(negedge clk);
        check("halt run_state", run_state, 0);
        check("halt reason", halt_reason, 1);
        repeat (3) @(negedge clk);
        check("halt pc frozen", cpu_pc, 12'h004);

        // STEP 3 then STEP 0 (one instruction).
        load_core(12'h000);
        send(STEP, 16'd3, 16'h0);
        n_ex = 0;
        repeat (20) begin
            if (cpu_en && !cpu_fetch) n_ex++;
            @(negedge clk);
        end
        check("step3 exec count", n_ex, 3);
        check("step3 pc", cpu_pc, 12'h003);
        check("step3 run_state", run_state, 0);
        check("step3 reason", halt_reason, 2);
        send(STEP, 16'd0, 16'h0);
        n_ex = 0;
        repeat (20) begin
            if (cpu_en && !cpu_fetch) n_ex++;
            @(negedge clk);
        end
        check("step0 exec count", n_ex, 1);
        check("step0 pc", cpu_pc, 12'h004);

        // Breakpoint at 0x005, then resume past it.
        load_core(12'h000);
        send(SETBP, 16'h1005, 16'h0);
        send(RUN, 16'h0, 16'h0);
        n_ex = 0;
        for (int k = 0; k < 40 && run_state != 2'd0; k++) begin
            if (cpu_en && !cpu_fetch) n_ex++;
            @(negedge clk);
        end
        check("bp run_state", run_state, 0);
        check("bp exec count", n_ex, 5);
        check("bp pc", cpu_pc, 12'h005);
        check("bp fetch", cpu_fetch, 1);
        check("bp reason", halt_reason, 3);
        send(RUN, 16'h0, 16'h0);
        repeat (6) @(negedge clk);
        check("bp resume pc", cpu_pc, 12'h008);
        check("bp resume running", run_state, 1);
        send(MEMRD, 16'h0010, 16'h0);
        check("memrd run err", hif.cmd_err, 1);
        check("memrd run state", run_state, 1);
        check("memrd run no read", mem_read, 0);
        @(negedge clk);
        check("memrd run no done", hif.cmd_done, 0);
        check("memrd run rdata", hif.host_rdata, 16'hBEEF);
        send(HALT, 16'h0, 16'h0);
        for (int k = 0; k < 20 && run_state != 2'd0; k++) @(negedge clk);
        check("bp2 halted", run_state, 0);
        check("bp2 reason", halt_reason, 1);
        send(SETBP, 16'h0000, 16'h0);

        // STP at 0x002.
        stp_on = 1'b1;
        stp_pc = 12'h002;
        load_core(12'h000);
        send(RUN, 16'h0, 16'h0);
        repeat (6) @(negedge clk);
        check("stp 2nd exec enabled", cpu_en, 1);
        @(negedge clk);
        check("stp cpu_en", cpu_en, 0);
        check("stp run_state", run_state, 2);
        send(RUN, 16'h0, 16'h0);
        check("stp run err", hif.cmd_err, 1);
        check("stp run cpu_en", cpu_en, 0);
        check("stp run state", run_state, 2);
        send(STEP, 16'd2, 16'h0);
        check("stp step err", hif.cmd_err, 1);
        send(MEMRD, 16'h0020, 16'h0);
        check("stp memrd state", run_state, 3);
        check("stp memrd err", hif.cmd_err, 0);
        @(negedge clk);
        check("stp memrd done", hif.cmd_done, 1);
        check("stp memrd rdata", hif.host_rdata, 16'h1234);
        check("stp memrd back", run_state, 2);

        // Reset in the middle of a host write.
        send(SETBP, 16'h1003, 16'h0);
        send(MEMWR, 16'h0030, 16'h5555);
        check("rstmid mem_write before", mem_write, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid mem_write", mem_write, 0);
        check("rstmid run_state", run_state, 0);
        @(negedge clk);
        rst = 1'b0;
        stp_on = 1'b0;
        check("rstmid reason", halt_reason, 0);
        check("rstmid done", hif.cmd_done, 0);
        load_core(12'h000);
        send(RUN, 16'h0, 16'h0);
        repeat (8) @(negedge clk);
        check("rstmid bp cleared pc", cpu_pc, 12'h004);
        check("rstmid bp cleared running", cpu_en, 1);
        send(HALT, 16'h0, 16'h0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
